// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add multiplier that time-shares an external N-bit ALU
module alu_mul_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product,
    output logic [2:0]   alu_sel,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_result
);
    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SHL = 3'b001;
    localparam logic [2:0] SEL_SHR = 3'b101;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, TEST, ADD, SHL, SHR, DONE} state_t;

    state_t state, state_nx;
    logic [N-1:0] mcand, mplier, acc, product_q;

    // state register and datapath registers; each ALU state writes back its own result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            product_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    mcand  <= op_a;
                    mplier <= op_b;
                    acc    <= '0;
                end
                ADD:  acc       <= alu_result;
                SHL:  mcand     <= alu_result;
                SHR:  mplier    <= alu_result;
                DONE: product_q <= acc;
                default: ;
            endcase
        end
    end

    // next state plus ALU drive, all decoded from the registered state
    always_comb begin
        state_nx = state;
        alu_sel  = SEL_ADD;
        alu_a    = '0;
        alu_b    = '0;
        case (state)
            IDLE: state_nx = start ? TEST : IDLE;
            TEST: state_nx = (mplier == '0) ? DONE : (mplier[0] ? ADD : SHL);
            ADD: begin
                alu_a    = acc;
                alu_b    = mcand;
                state_nx = SHL;
            end
            SHL: begin
                alu_sel  = SEL_SHL;
                alu_a    = mcand;
                alu_b    = ONE;
                state_nx = SHR;
            end
            SHR: begin
                alu_sel  = SEL_SHR;
                alu_a    = mplier;
                alu_b    = ONE;
                state_nx = TEST;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign product = (state == DONE) ? acc : product_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed checks of the multiply sequencer against a behavioural ALU
module tb_alu_mul_seq;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [31:0] op_a = 0, op_b = 0;
    logic        busy, done;
    logic [31:0] product, alu_a, alu_b, alu_result;
    logic [2:0]  alu_sel;
    int          n_checks = 0, n_fail = 0;
    int          edges, act;
    logic [31:0] seq;

    alu_mul_seq #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    assign alu_result = (alu_sel == 3'b000) ? alu_a + alu_b :
                        (alu_sel == 3'b001) ? alu_a << alu_b[4:0] :
                        (alu_sel == 3'b101) ? alu_a >> alu_b[4:0] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input int exp_l,
                       input logic [31:0] exp_p, input bit spam);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1;
        @(posedge clk);
        #1;
        if (spam) begin
            op_a = 9;
            op_b = 9;
        end else start = 0;
        chk("busy_after_start", {31'b0, busy}, 1);
        edges = 0;
        act   = 0;
        seq   = 0;
        while (!done && edges < 300) begin
            @(posedge clk);
            edges++;
            #1;
            if (!done && (alu_a != 0 || alu_b != 0)) begin
                seq = (seq << 3) | {29'b0, alu_sel};
                act++;
            end
        end
        start = 0;
        chk("latency", edges, exp_l);
        chk("done_pulse", {31'b0, done}, 1);
        chk("product_at_done", product, exp_p);
        @(posedge clk);
        #1;
        chk("done_drops", {31'b0, done}, 0);
        chk("busy_drops", {31'b0, busy}, 0);
        chk("product_held", product, exp_p);
    endtask

    initial begin
        #2;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_product", product, 0);
        chk("rst_alu_sel", {29'b0, alu_sel}, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        #10 rst_n = 1;

        run(32'd6, 32'd5, 12, 32'd30, 0);
        chk("seq_6x5", seq, 32'o01515015);
        chk("active_6x5", act, 8);

        run(32'd1234, 32'd0, 1, 32'd0, 0);
        chk("active_x0", act, 0);

        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 129, 32'h0000_0001, 0);
        run(32'h0001_0000, 32'h0001_0000, 53, 32'h0, 0);
        run(32'hFFFF_FFF9, 32'd3, 9, 32'hFFFF_FFEB, 0);

        run(32'd6, 32'd5, 12, 32'd30, 1);

        // back-to-back: restart in the idle cycle right after done
        run(32'd7, 32'd2, 8, 32'd14, 0);

        @(negedge clk);
        op_a  = 100;
        op_b  = 100;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        @(posedge clk);
        #1;
        chk("in_shl_sel", {29'b0, alu_sel}, 3'b001);
        rst_n = 0;
        #1;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_product", product, 0);
        chk("abort_alu_a", alu_a, 0);
        #2 rst_n = 1;

        run(32'd3, 32'd4, 11, 32'd12, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Iterative multiply sequencer that computes the low N bits of op_a × op_b by time-sharing the existing N-bit ALU through its sel/A/B/alu_result interface, using only ADD, SHL and SHR. It sits beside the ALU. While busy is high, the top-level operand mux hands the ALU to this block, which gives the core a RISC-V MUL (low-word) result without a hardware multiplier. The low N bits are identical for signed and unsigned operands, so no sign handling is needed.

## Interface
- N, 32, operand/result width; must match the ALU's N.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- op_a  in  N  multiplicand, latched on accepted start.
- op_b  in  N  multiplier, latched on accepted start.
- busy  out  1  high in every state except IDLE; top level selects this block's ALU drive while high.
- done  out  1  one-cycle pulse, high while state is DONE.
- product  out  N  low N bits of op_a*op_b; valid from the done cycle, held until the next accepted start.
- alu_sel  out  3  ALU operation: ADD=3'b000, SHL=3'b001, SHR=3'b101.
- alu_a  out  N  ALU operand A.
- alu_b  out  N  ALU operand B.
- alu_result  in  N  combinational ALU result for the current alu_sel/alu_a/alu_b.

## Operation
- Internal registers: mcand (N), mplier (N), acc (N), product (N), state.
- IDLE: if start, then mcand<=op_a, mplier<=op_b, acc<=0, go to TEST. Otherwise stay.
- TEST: if mplier==0, go to DONE. Else if mplier[0], go to ADD. Else go to SHL.
- ADD: drive ADD with acc and mcand; acc<=alu_result; go to SHL.
- SHL: drive SHL with mcand and 1; mcand<=alu_result; go to SHR.
- SHR: drive SHR with mplier and 1; mplier<=alu_result; go to TEST.
- DONE: product<=acc (visible the following cycle; acc is also driven directly so product reads correctly during done); done=1; go to IDLE.
- Implementation: product output = (state==DONE) ? acc : product register. Register it on DONE exit.
- In IDLE, TEST and DONE: alu_sel=ADD, alu_a=0, alu_b=0.
- All arithmetic is modulo 2^N. Carries out of ADD and bits shifted out by SHL are discarded.
- Early termination: the loop ends as soon as mplier reaches 0. At most N iterations.
- start while busy (including the DONE cycle) is ignored, not queued.
- The ALU's zero_flag and sign_flag are not used.

## Timing
- Reset (asynchronous, any time including mid-operation): state=IDLE, busy=0, done=0, product=0, mcand=mplier=acc=0, alu_sel=ADD, alu_a=alu_b=0. Any in-progress multiply is abandoned.
- Outputs busy, done, alu_sel, alu_a and alu_b decode from registered state only. No input-to-output combinational paths except alu_result to the register D inputs.
- Let E0 be the edge that samples start in IDLE, k the index of the highest set bit of op_b, and b_i its bits.
- done is high in the cycle after edge E0+L, where L = 1 + sum over i=0..k of (3+b_i).
- For op_b=0, L=1.
- busy rises after E0 and falls after the edge that leaves DONE.
- Worst case (op_b all ones): L = 4N+1 = 129 for N=32.
- Back-to-back operation: start may be asserted in the IDLE cycle right after DONE. There is one idle cycle minimum between jobs.

## Test plan
- op_a=6, op_b=5 -> done after L=12 edges, product=30. The ALU sequence is ADD,SHL,SHR,SHL,SHR,ADD,SHL,SHR.
- op_a=1234, op_b=0 -> done after L=1, product=0, with no ADD/SHL/SHR cycles.
- op_a=32'hFFFF_FFFF, op_b=32'hFFFF_FFFF -> L=129, product=32'h0000_0001. Also op_a=32'h0001_0000, op_b=32'h0001_0000 -> product=0 (wrap-around).
- op_a=-7 (32'hFFFF_FFF9), op_b=3 -> product=32'hFFFF_FFEB (-21), L=9.
- Start 6×5. Pulse start again with op_a=9, op_b=9 during ADD, SHL and DONE -> all ignored; product=30, single done pulse.
- Start 100×100. Drop rst_n for 3 ns mid-SHL -> immediately busy=0 and product=0. After release, 3×4 -> product=12.
